// File: rtl/ex_stage_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencer: datapath width, MUL opcode,
// ALUOp encodings and the sequencer state encoding.
package ex_stage_ctrl_pkg;

    localparam int          EX_WORD       = 64;
    localparam logic [10:0] EX_MUL_OPCODE = 11'h4D8;

    // ALUOp encodings understood by the execute datapath
    localparam logic [1:0]  ALUOP_ADD   = 2'b00;  // loads/stores: address add
    localparam logic [1:0]  ALUOP_CBZ   = 2'b01;  // pass operand B, zero flag drives CBZ
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;  // register-register arithmetic

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_HOLD = 2'd3
    } ex_state_e;

endpackage

// File: rtl/ex_stage_ctrl_if.sv
// Decode-side, datapath-side and memory-side signals of the execute stage.
// slave  : view of the execute-stage sequencer itself.
// master : view of the surrounding pipeline (decode, datapath, memory stage).
interface ex_stage_ctrl_if #(
    parameter int WORD = 64
);
    // decode -> execute
    logic            id_valid;
    logic            id_ready;
    logic [WORD-1:0] id_pc;
    logic [WORD-1:0] id_rd1;
    logic [WORD-1:0] id_rd2;
    logic [WORD-1:0] id_imm;
    logic [10:0]     id_opcode;
    logic [1:0]      id_alu_op;
    logic            id_alu_src;
    logic            id_branch;
    logic            id_uncond;

    // execute register -> datapath
    logic [WORD-1:0] ex_pc;
    logic [WORD-1:0] ex_rd1;
    logic [WORD-1:0] ex_rd2;
    logic [WORD-1:0] ex_imm;
    logic [10:0]     ex_opcode;
    logic [1:0]      ex_alu_op;
    logic            ex_alu_src;

    // datapath -> sequencer
    logic [WORD-1:0] dp_alu_result;
    logic            dp_zero;
    logic [WORD-1:0] dp_branch_target;

    // execute -> memory stage / fetch
    logic            mem_valid;
    logic            mem_ready;
    logic [WORD-1:0] mem_result;
    logic [WORD-1:0] mem_store_data;
    logic            br_taken;
    logic [WORD-1:0] br_target;
    logic            busy;

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_opcode,
               id_alu_op, id_alu_src, id_branch, id_uncond,
        output id_ready,
        output ex_pc, ex_rd1, ex_rd2, ex_imm, ex_opcode, ex_alu_op, ex_alu_src,
        input  dp_alu_result, dp_zero, dp_branch_target,
        output mem_valid, mem_result, mem_store_data, br_taken, br_target, busy,
        input  mem_ready
    );

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_opcode,
               id_alu_op, id_alu_src, id_branch, id_uncond,
        input  id_ready,
        input  ex_pc, ex_rd1, ex_rd2, ex_imm, ex_opcode, ex_alu_op, ex_alu_src,
        output dp_alu_result, dp_zero, dp_branch_target,
        input  mem_valid, mem_result, mem_store_data, br_taken, br_target, busy,
        output mem_ready
    );

endinterface

// File: rtl/ex_mul_seq.sv
// Shift-add multiplier used by the execute stage for MUL. Loaded on start_i,
// then one partial product per cycle; product_o is the low WORD bits.
// MUL_EARLY_EXIT_EN: when defined, done_o rises as soon as the remaining
// multiplier bits are all zero instead of after a fixed WORD iterations.
module ex_mul_seq #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [WORD-1:0] mcand_i,
    input  logic [WORD-1:0] mplier_i,
    output logic            done_o,
    output logic [WORD-1:0] product_o
);

    localparam int             CW   = $clog2(WORD) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WORD);

    logic            run_q;
    logic [CW-1:0]   cnt_q;
    logic [WORD-1:0] acc_q;
    logic [WORD-1:0] mcand_q;
    logic [WORD-1:0] mplier_q;

`ifdef MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations cannot change acc.
    assign done_o = run_q & ((mplier_q == '0) | (cnt_q == LAST));
`else
    assign done_o = run_q & (cnt_q == LAST);
`endif

    assign product_o = acc_q;

    // Load operands on start, then accumulate/shift one bit per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
        end else if (run_q) begin
            if (done_o) begin
                run_q <= 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_stage_ctrl.sv
// Execute-stage sequencer: owns the ID/EX register, resolves branches with the
// external datapath, runs MUL on the shift-add sequencer and holds the result
// for the memory stage under valid/ready. A taken branch produces a one-cycle
// br_taken flush pulse during which no new instruction is accepted.
// Optional build macro: MUL_EARLY_EXIT_EN (early MUL termination, see ex_mul_seq).
module ex_stage_ctrl
    import ex_stage_ctrl_pkg::*;
#(
    parameter int          WORD       = EX_WORD,
    parameter logic [10:0] MUL_OPCODE = EX_MUL_OPCODE
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_stage_ctrl_if.slave     bus
);

    ex_state_e       state_q;
    logic [WORD-1:0] ex_pc_q;
    logic [WORD-1:0] ex_rd1_q;
    logic [WORD-1:0] ex_rd2_q;
    logic [WORD-1:0] ex_imm_q;
    logic [10:0]     ex_opcode_q;
    logic [1:0]      ex_alu_op_q;
    logic            ex_alu_src_q;
    logic            id_branch_q;
    logic            id_uncond_q;
    logic [WORD-1:0] mem_result_q;
    logic            mem_valid_q;
    logic            br_taken_q;
    logic [WORD-1:0] br_target_q;

    logic            id_ready;
    logic            handshake;
    logic            is_mul;
    logic            taken;
    logic            mul_done;
    logic [WORD-1:0] mul_product;

    // Accept in IDLE, or in HOLD when the result drains this cycle and no flush is pending.
    always_comb begin
        id_ready = (state_q == ST_IDLE) |
                   ((state_q == ST_HOLD) & bus.mem_ready & ~br_taken_q);
    end

    assign handshake = bus.id_valid & id_ready;
    assign is_mul    = (bus.id_opcode == MUL_OPCODE);
    assign taken     = id_uncond_q | (id_branch_q & bus.dp_zero);

    ex_mul_seq #(
        .WORD (WORD)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (handshake & is_mul),
        .mcand_i   (bus.id_rd1),
        .mplier_i  (bus.id_rd2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Sequencer FSM with ID/EX capture and registered memory/branch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ex_pc_q      <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_opcode_q  <= '0;
            ex_alu_op_q  <= '0;
            ex_alu_src_q <= 1'b0;
            id_branch_q  <= 1'b0;
            id_uncond_q  <= 1'b0;
            mem_result_q <= '0;
            mem_valid_q  <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
        end else begin
            // Handshakes only occur in IDLE or HOLD, so capture is state independent.
            if (handshake) begin
                ex_pc_q      <= bus.id_pc;
                ex_rd1_q     <= bus.id_rd1;
                ex_rd2_q     <= bus.id_rd2;
                ex_imm_q     <= bus.id_imm;
                ex_opcode_q  <= bus.id_opcode;
                ex_alu_op_q  <= bus.id_alu_op;
                ex_alu_src_q <= bus.id_alu_src;
                id_branch_q  <= bus.id_branch;
                id_uncond_q  <= bus.id_uncond;
            end

            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        state_q <= is_mul ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    mem_result_q <= bus.dp_alu_result;
                    br_taken_q   <= taken;
                    br_target_q  <= bus.dp_branch_target;
                    mem_valid_q  <= 1'b1;
                    state_q      <= ST_HOLD;
                end
                ST_MUL: begin
                    if (mul_done) begin
                        mem_result_q <= mul_product;
                        mem_valid_q  <= 1'b1;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Flush pulse lasts exactly the first HOLD cycle.
                    br_taken_q <= 1'b0;
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (handshake) begin
                            state_q <= is_mul ? ST_MUL : ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_rd1         = ex_rd1_q;
    assign bus.ex_rd2         = ex_rd2_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_opcode      = ex_opcode_q;
    assign bus.ex_alu_op      = ex_alu_op_q;
    assign bus.ex_alu_src     = ex_alu_src_q;
    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_result     = mem_result_q;
    assign bus.mem_store_data = ex_rd2_q;
    assign bus.br_taken       = br_taken_q;
    assign bus.br_target      = br_target_q;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Self-checking bench for ex_stage_ctrl: directed cases plus randomized
// instruction streams with random backpressure and back-to-back issue,
// compared against a behavioural instruction-level model.
`timescale 1ns/1ps
module tb_ex_stage_ctrl;
    import ex_stage_ctrl_pkg::*;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic [10:0]  opcode;
        logic [1:0]   alu_op;
        logic         alu_src;
        logic         branch;
        logic         uncond;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_stage_ctrl_if #(.WORD(W)) bus();

    ex_stage_ctrl #(
        .WORD       (W),
        .MUL_OPCODE (EX_MUL_OPCODE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural execute datapath (ALU, operand mux, branch adder)
    function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            ALUOP_ADD:   return a + b;
            ALUOP_CBZ:   return b;
            ALUOP_RTYPE: return a + b;
            default:     return a - b;
        endcase
    endfunction

    assign bus.dp_alu_result    = alu_f(bus.ex_alu_op, bus.ex_rd1,
                                        bus.ex_alu_src ? bus.ex_imm : bus.ex_rd2);
    assign bus.dp_zero          = (bus.dp_alu_result == '0);
    assign bus.dp_branch_target = bus.ex_pc + (bus.ex_imm << 2);

    // Instruction-level reference: result, branch decision, target, capture-to-valid latency.
    task automatic model(input instr_t in, output logic [W-1:0] res, output logic tk,
                         output logic [W-1:0] tgt, output int lat);
        if (in.opcode == EX_MUL_OPCODE) begin
            res = in.rd1 * in.rd2;
            tk  = 1'b0;
            tgt = '0;
`ifdef MUL_EARLY_EXIT_EN
            lat = 1;
            for (int b = 0; b < W; b++) if (in.rd2[b]) lat = b + 2;
`else
            lat = W + 1;
`endif
        end else begin
            res = alu_f(in.alu_op, in.rd1, in.alu_src ? in.imm : in.rd2);
            tk  = in.uncond | (in.branch & (res == '0));
            tgt = in.pc + in.imm * 4;
            lat = 1;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input instr_t in, input logic v);
        bus.id_valid   = v;
        bus.id_pc      = in.pc;
        bus.id_rd1     = in.rd1;
        bus.id_rd2     = in.rd2;
        bus.id_imm     = in.imm;
        bus.id_opcode  = in.opcode;
        bus.id_alu_op  = in.alu_op;
        bus.id_alu_src = in.alu_src;
        bus.id_branch  = in.branch;
        bus.id_uncond  = in.uncond;
    endtask

    function automatic instr_t mk(input logic [W-1:0] pc, input logic [W-1:0] rd1,
                                  input logic [W-1:0] rd2, input logic [W-1:0] imm,
                                  input logic [10:0] opc, input logic [1:0] aop,
                                  input logic src, input logic br, input logic un);
        instr_t r;
        r.pc = pc; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm; r.opcode = opc;
        r.alu_op = aop; r.alu_src = src; r.branch = br; r.uncond = un;
        return r;
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r = mk(rand64(), rand64(), rand64(), rand64(), 11'($urandom_range(0, 2047)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
            r.opcode = EX_MUL_OPCODE;
            if ($urandom_range(0, 1) == 1) r.rd2 = 64'($urandom_range(0, 255));
        end else begin
            if (r.opcode == EX_MUL_OPCODE) r.opcode[0] = ~r.opcode[0];
            r.branch = ($urandom_range(0, 3) == 0);
            r.uncond = ($urandom_range(0, 5) == 0);
            if (r.branch && $urandom_range(0, 1) == 1) begin
                r.rd2 = '0; r.alu_op = ALUOP_CBZ; r.alu_src = 1'b0;
            end
        end
        return r;
    endfunction

    // Issue cur (unless already captured), wait for its result, apply bp cycles of
    // backpressure, then release; optionally offer nxt in the release cycle.
    task automatic run_one(input string nm, input instr_t cur, input int bp, input bit chain,
                           input instr_t nxt, input bit captured, output bit nxt_captured);
        logic [W-1:0] er, et, hold_res;
        logic         etk, exp_rdy;
        int           elat, lat;
        model(cur, er, etk, et, elat);
        if (!captured) begin
            check({nm, ".idle_ready"}, 64'(bus.id_ready), 64'(1));
            drive_id(cur, 1'b1);
            tick();
            drive_id(cur, 1'b0);
        end
        check({nm, ".busy"}, 64'(bus.busy), 64'(1));
        lat = 0;
        while (!bus.mem_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({nm, ".latency"}, 64'(lat), 64'(elat));
        check({nm, ".mem_result"}, bus.mem_result, er);
        check({nm, ".store_data"}, bus.mem_store_data, cur.rd2);
        check({nm, ".ex_opcode"}, 64'(bus.ex_opcode), 64'(cur.opcode));
        check({nm, ".br_taken"}, 64'(bus.br_taken), 64'(etk));
        if (etk) check({nm, ".br_target"}, bus.br_target, et);
        hold_res = bus.mem_result;
        for (int j = 0; j < bp; j++) begin
            bus.mem_ready = 1'b0;
            drive_id(rand_instr(), 1'($urandom_range(0, 1)));
            #1;
            check({nm, ".bp_id_ready"}, 64'(bus.id_ready), 64'(0));
            tick();
            check({nm, ".bp_mem_valid"}, 64'(bus.mem_valid), 64'(1));
            check({nm, ".bp_mem_result"}, bus.mem_result, hold_res);
            check({nm, ".bp_br_taken"}, 64'(bus.br_taken), 64'(0));
        end
        bus.mem_ready = 1'b1;
        drive_id(nxt, chain);
        exp_rdy = !(bp == 0 && etk);
        #1;
        if (chain) check({nm, ".hold_id_ready"}, 64'(bus.id_ready), 64'(exp_rdy));
        tick();
        drive_id(nxt, 1'b0);
        nxt_captured = chain && exp_rdy;
        check({nm, ".rel_mem_valid"}, 64'(bus.mem_valid), 64'(0));
        check({nm, ".rel_br_taken"}, 64'(bus.br_taken), 64'(0));
        check({nm, ".rel_busy"}, 64'(bus.busy), 64'(nxt_captured));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        instr_t cur, nxt, none;
        bit     cap;
        none = mk('0, '0, '0, '0, 11'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b0;
        drive_id(none, 1'b0);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.mem_valid", 64'(bus.mem_valid), 64'(0));
        check("rst.br_taken", 64'(bus.br_taken), 64'(0));
        check("rst.mem_result", bus.mem_result, 64'(0));
        check("rst.br_target", bus.br_target, 64'(0));
        check("rst.ex_pc", bus.ex_pc, 64'(0));
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.id_ready", 64'(bus.id_ready), 64'(1));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ADD 5+7
        cur = mk(64'h0, 64'd5, 64'd7, 64'h0, 11'h458, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        run_one("add", cur, 0, 1'b0, none, 1'b0, cap);
        // CBZ taken; next instruction offered during the flush pulse must be refused
        cur = mk(64'h100, 64'h55, 64'h0, 64'd3, 11'h5A0, ALUOP_CBZ, 1'b0, 1'b1, 1'b0);
        nxt = mk(64'h0, 64'd1, 64'd2, 64'h0, 11'h458, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        run_one("cbz", cur, 0, 1'b1, nxt, 1'b0, cap);
        // MUL all-ones * 3 wraps to -3
        cur = mk(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h0, EX_MUL_OPCODE, ALUOP_RTYPE,
                 1'b0, 1'b0, 1'b0);
        run_one("mul3", cur, 0, 1'b0, none, 1'b0, cap);
        // Backpressure 10 cycles then back-to-back accept
        cur = mk(64'h0, 64'd40, 64'd2, 64'h0, 11'h458, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        nxt = mk(64'h0, 64'd100, 64'd23, 64'h0, 11'h458, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        run_one("bp", cur, 10, 1'b1, nxt, 1'b0, cap);
        check("bp.chain_accepted", 64'(cap), 64'(1));
        run_one("chained", nxt, 0, 1'b0, none, cap, cap);
        // Unconditional branch with negative offset
        cur = mk(64'h40, 64'h0, 64'h9, 64'hFFFF_FFFF_FFFF_FFFE, 11'h0A0, ALUOP_CBZ,
                 1'b0, 1'b0, 1'b1);
        run_one("b_neg", cur, 2, 1'b0, none, 1'b0, cap);
        // MUL by zero
        cur = mk(64'h0, rand64(), 64'h0, 64'h0, EX_MUL_OPCODE, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        run_one("mul0", cur, 1, 1'b0, none, 1'b0, cap);

        // Reset in the middle of a long MUL
        cur = mk(64'h0, rand64(), 64'h8000_0000_0000_0001, 64'h0, EX_MUL_OPCODE, ALUOP_RTYPE,
                 1'b0, 1'b0, 1'b0);
        drive_id(cur, 1'b1);
        tick();
        drive_id(cur, 1'b0);
        repeat (20) tick();
        check("mulrst.busy_before", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mulrst.busy", 64'(bus.busy), 64'(0));
        check("mulrst.mem_valid", 64'(bus.mem_valid), 64'(0));
        check("mulrst.ex_rd1", bus.ex_rd1, 64'(0));
        check("mulrst.ex_opcode", 64'(bus.ex_opcode), 64'(0));
        check("mulrst.id_ready", 64'(bus.id_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        cur = mk(64'h0, 64'd6, 64'd7, 64'h0, EX_MUL_OPCODE, ALUOP_RTYPE, 1'b0, 1'b0, 1'b0);
        run_one("mul6x7", cur, 0, 1'b0, none, 1'b0, cap);

        // Randomized instruction stream
        cap = 1'b0;
        cur = rand_instr();
        for (int i = 0; i < 40; i++) begin
            nxt = rand_instr();
            run_one("rand", cur, $urandom_range(0, 3), 1'($urandom_range(0, 1)), nxt, cap, cap);
            cur = nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
